stage_decode: RTL and testbench
===============================

# stage_decode

Second pipeline stage, directly downstream of the fetch stage. It holds the IF/ID pipeline register, decodes RV32I instructions into control signals and immediates, and reads the 32x32 register file with write-first bypass from writeback. It also detects load-use hazards and freezes fetch through the fetch stage's `pc_write_disable` input. Its outputs feed the ID/EX register in the top level.

## Interface
- `NOP_INSTR`, 32'h00000013 — instruction word held in IF/ID on reset, flush, or bubble.
- `EXC_ILLEGAL`, 3'd2 — exception code raised for an unsupported opcode.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `in_PC`  in  32  fetch PC
- `in_instruction`  in  32  fetch instruction word
- `in_fetch_stall`  in  1  icache busy; fetch output is not valid this cycle
- `in_exception_vector`  in  3  exception code from fetch
- `in_flush`  in  1  branch taken in execute
- `in_stall`  in  1  stall request from a later stage
- `in_ex_mem_read`, `in_ex_rd`  in  1/5  instruction currently in execute is a load, and its destination register
- `in_wb_write_en`, `in_wb_rd`, `in_wb_data`  in  1/5/32  register file write port
- `out_pc_write_disable`  out  1  to fetch
- `out_valid`  out  1  decoded instruction is real (not a bubble)
- `out_PC`, `out_imm`, `out_rs1_data`, `out_rs2_data`  out  32 each
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each
- `out_funct3`, `out_funct7`  out  3/7
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_branch`, `out_jump`, `out_alu_src`  out  1 each
- `out_exception_vector`  out  3

## Operation
- IF/ID register fields: PC, instruction, valid, exception vector.
- IF/ID update, in priority order:
  - `reset` → NOP, PC 0, valid 0, exception 0.
  - `in_flush` → NOP, valid 0.
  - `hazard` or `in_stall` → hold current contents.
  - `in_fetch_stall` → capture a bubble (NOP, valid 0).
  - Otherwise → capture fetch outputs with valid 1.
- hazard = valid & `in_ex_mem_read` & (`in_ex_rd` ≠ 0) & ((rs1 used & `in_ex_rd` = rs1) | (rs2 used & `in_ex_rd` = rs2)).
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 is used by BRANCH, STORE, OP.
- `out_pc_write_disable` = (hazard | `in_stall`) & !`in_flush`. A flush always releases fetch so that the branch target loads.
- Register file:
  - Sync reset clears all registers to 0.
  - Write occurs on `in_wb_write_en` & `in_wb_rd` ≠ 0. x0 always reads 0.
  - Combinational read; a same-cycle write to the read index returns `in_wb_data`.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode with valid 1 sets `out_exception_vector` = `EXC_ILLEGAL`, unless the captured fetch vector is nonzero, in which case the fetch vector wins.
- Control signals:
  - reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - mem_read and mem_to_reg: LOAD.
  - mem_write: STORE.
  - branch: BRANCH.
  - jump: JAL, JALR.
  - alu_src: all supported opcodes except OP and BRANCH.
- All control outputs and `out_valid` are forced to 0 when valid = 0, hazard = 1, or the exception vector is nonzero.
- Immediates follow RV32I I/S/B/U/J formats, sign-extended to 32 bits. B and J immediates have bit 0 = 0. U immediate is instr[31:12] followed by 12 zero bits. OP and unsupported opcodes produce an immediate of 0.

## Timing
- Fetch outputs sampled at edge N appear on decode outputs during cycle N+1 (1-cycle latency).
- Decode outputs are combinational from IF/ID and the register file; there is no output register.
- Reset values: IF/ID = NOP with valid 0, so every control output, `out_valid`, and `out_exception_vector` read 0, and `out_PC` reads 0. `out_pc_write_disable` reads 0.
- Reset asserted mid-stall clears the hold state on the next edge.
- A load-use hazard holds for exactly 1 cycle: the load advances out of execute and hazard drops.
- A flush asserted together with a hazard leaves a bubble in IF/ID and does not disable the PC write.

## Structure
- Shared package `decode_pkg` holds:
  - opcode localparams (7'b0110111 LUI … 7'b0110011 OP);
  - `NOP_INSTR`;
  - exception codes;
  - an imm-type enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
- Sub-module `register_file`: 32x32, 2 read ports, 1 write port, write-first bypass, sync reset.

## Test plan
- Reset, then fetch `addi x1,x0,5` (32'h00500093) at PC 0x200 → next cycle `out_valid`=1, `out_imm`=5, `out_rd`=1, `out_reg_write`=1, `out_alu_src`=1, `out_PC`=0x200.
- Writeback writes x3 = 0xDEADBEEF in the same cycle that decode holds `add x4,x3,x3` → `out_rs1_data` = `out_rs2_data` = 0xDEADBEEF.
- Writeback writes x0 = 7 → a later read of x0 returns 0.
- `in_ex_mem_read`=1, `in_ex_rd`=5, decode holds `add x6,x5,x1` → `out_pc_write_disable`=1 and `out_reg_write`=0 for 1 cycle; IF/ID is unchanged; decoding resumes the next cycle.
- `in_flush`=1 together with a hazard → `out_pc_write_disable`=0; the next cycle shows `out_valid`=0.
- `in_fetch_stall`=1 → bubble captured (`out_valid`=0). Instruction 32'hFFFFFFFF → `out_exception_vector`=2 and all control outputs 0. `beq` with imm −4 → `out_imm`=32'hFFFFFFFC.

Source files
------------

// File: rtl/stage_decode_pkg.sv
// Shared decode definitions: RV32I opcodes, the NOP word, exception codes,
// immediate formats and the immediate generator.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam logic [2:0] EXC_NONE    = 3'd0;
    localparam logic [2:0] EXC_ILLEGAL = 3'd2;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
        logic alu_src;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input imm_type_e imm_type, input logic [31:0] instr);
        logic [31:0] imm;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/stage_decode_if.sv
// Fetch-side, hazard/writeback inputs and decoded outputs of the decode stage.
interface stage_decode_if;

    logic [31:0] in_PC;
    logic [31:0] in_instruction;
    logic        in_fetch_stall;
    logic [2:0]  in_exception_vector;
    logic        in_flush;
    logic        in_stall;
    logic        in_ex_mem_read;
    logic [4:0]  in_ex_rd;
    logic        in_wb_write_en;
    logic [4:0]  in_wb_rd;
    logic [31:0] in_wb_data;

    logic        out_pc_write_disable;
    logic        out_valid;
    logic [31:0] out_PC;
    logic [31:0] out_imm;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_mem_to_reg;
    logic        out_branch;
    logic        out_jump;
    logic        out_alu_src;
    logic [2:0]  out_exception_vector;

    // Surrounding pipeline side
    modport master (
        output in_PC, in_instruction, in_fetch_stall, in_exception_vector,
               in_flush, in_stall, in_ex_mem_read, in_ex_rd,
               in_wb_write_en, in_wb_rd, in_wb_data,
        input  out_pc_write_disable, out_valid, out_PC, out_imm,
               out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_reg_write, out_mem_read,
               out_mem_write, out_mem_to_reg, out_branch, out_jump,
               out_alu_src, out_exception_vector
    );

    // Decode stage side
    modport slave (
        input  in_PC, in_instruction, in_fetch_stall, in_exception_vector,
               in_flush, in_stall, in_ex_mem_read, in_ex_rd,
               in_wb_write_en, in_wb_rd, in_wb_data,
        output out_pc_write_disable, out_valid, out_PC, out_imm,
               out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd,
               out_funct3, out_funct7, out_reg_write, out_mem_read,
               out_mem_write, out_mem_to_reg, out_branch, out_jump,
               out_alu_src, out_exception_vector
    );

endinterface

// File: rtl/stage_decode_register_file.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, synchronous clear. x0 is hardwired to zero.
module register_file (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0][4:0] raddr,
    output logic [1:0][31:0] rdata,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [31:0]     wdata
);

    logic [31:0] regs_reg [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= 32'b0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_reg[waddr] <= wdata;
        end
    end

    // Writes to x0 are dropped, so the bypass must never forward to x0 either
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            assign rdata[gi] = (raddr[gi] == 5'd0)                ? 32'b0 :
                               (we && (waddr == raddr[gi]))       ? wdata :
                                                                    regs_reg[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/stage_decode.sv
// Decode stage: IF/ID register, RV32I control/immediate decode, register
// file read and load-use hazard detection that freezes fetch.
module stage_decode
    import decode_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    stage_decode_if.slave bus
);

    logic [31:0] ifid_pc_reg;
    logic [31:0] ifid_instr_reg;
    logic        ifid_valid_reg;
    logic [2:0]  ifid_exc_reg;

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        supported;
    logic        rs1_used;
    logic        rs2_used;
    ctrl_t       dec_ctrl;
    imm_type_e   imm_type;
    logic        hazard;
    logic        kill;
    logic [2:0]  exc_vec;
    logic [1:0][4:0]  rf_raddr;
    logic [1:0][31:0] rf_rdata;

    assign opcode = ifid_instr_reg[6:0];
    assign rs1    = ifid_instr_reg[19:15];
    assign rs2    = ifid_instr_reg[24:20];

    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_pc_reg    <= 32'b0;
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            ifid_exc_reg   <= EXC_NONE;
        end else if (bus.in_flush) begin
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            ifid_exc_reg   <= EXC_NONE;
        end else if (hazard || bus.in_stall) begin
            ifid_pc_reg    <= ifid_pc_reg;
        end else if (bus.in_fetch_stall) begin
            ifid_instr_reg <= NOP_INSTR;
            ifid_valid_reg <= 1'b0;
            ifid_exc_reg   <= EXC_NONE;
        end else begin
            ifid_pc_reg    <= bus.in_PC;
            ifid_instr_reg <= bus.in_instruction;
            ifid_valid_reg <= 1'b1;
            ifid_exc_reg   <= bus.in_exception_vector;
        end
    end

    always_comb begin
        supported = 1'b0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        dec_ctrl  = '0;
        imm_type  = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                supported          = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_U;
            end
            OPC_JAL: begin
                supported          = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_J;
            end
            OPC_JALR: begin
                supported          = 1'b1;
                rs1_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_I;
            end
            OPC_BRANCH: begin
                supported       = 1'b1;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                dec_ctrl.branch = 1'b1;
                imm_type        = IMM_B;
            end
            OPC_LOAD: begin
                supported           = 1'b1;
                rs1_used            = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                imm_type            = IMM_I;
            end
            OPC_STORE: begin
                supported          = 1'b1;
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_S;
            end
            OPC_OP_IMM: begin
                supported          = 1'b1;
                rs1_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_type           = IMM_I;
            end
            OPC_OP: begin
                supported          = 1'b1;
                rs1_used           = 1'b1;
                rs2_used           = 1'b1;
                dec_ctrl.reg_write = 1'b1;
            end
            default: begin
                supported = 1'b0;
            end
        endcase
    end

    assign hazard = ifid_valid_reg && bus.in_ex_mem_read && (bus.in_ex_rd != 5'd0) &&
                    ((rs1_used && (bus.in_ex_rd == rs1)) || (rs2_used && (bus.in_ex_rd == rs2)));

    // A fetch-side exception outranks the illegal-opcode check
    assign exc_vec = (ifid_exc_reg != EXC_NONE)        ? ifid_exc_reg :
                     (ifid_valid_reg && !supported)    ? EXC_ILLEGAL  :
                                                         EXC_NONE;

    assign kill = !ifid_valid_reg || hazard || (exc_vec != EXC_NONE);

    assign rf_raddr[0] = rs1;
    assign rf_raddr[1] = rs2;

    register_file u_register_file (
        .clk   (clk),
        .reset (reset),
        .raddr (rf_raddr),
        .rdata (rf_rdata),
        .we    (bus.in_wb_write_en),
        .waddr (bus.in_wb_rd),
        .wdata (bus.in_wb_data)
    );

    // Flush wins so the branch target can be fetched even under a hazard
    assign bus.out_pc_write_disable = (hazard || bus.in_stall) && !bus.in_flush;

    assign bus.out_valid            = !kill;
    assign bus.out_PC               = ifid_pc_reg;
    assign bus.out_imm              = gen_imm(imm_type, ifid_instr_reg);
    assign bus.out_rs1_data         = rf_rdata[0];
    assign bus.out_rs2_data         = rf_rdata[1];
    assign bus.out_rs1              = rs1;
    assign bus.out_rs2              = rs2;
    assign bus.out_rd               = ifid_instr_reg[11:7];
    assign bus.out_funct3           = ifid_instr_reg[14:12];
    assign bus.out_funct7           = ifid_instr_reg[31:25];
    assign bus.out_reg_write        = dec_ctrl.reg_write  && !kill;
    assign bus.out_mem_read         = dec_ctrl.mem_read   && !kill;
    assign bus.out_mem_write        = dec_ctrl.mem_write  && !kill;
    assign bus.out_mem_to_reg       = dec_ctrl.mem_to_reg && !kill;
    assign bus.out_branch           = dec_ctrl.branch     && !kill;
    assign bus.out_jump             = dec_ctrl.jump       && !kill;
    assign bus.out_alu_src          = dec_ctrl.alu_src    && !kill;
    assign bus.out_exception_vector = exc_vec;

endmodule

// File: tb/tb_stage_decode.sv
// Scoreboard bench for stage_decode: expectations are queued as each
// instruction is presented and compared when it sits in decode.
module tb_stage_decode;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    stage_decode_if dif ();

    stage_decode u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic        pc_known;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  ctrl;
        logic [2:0]  exc;
        logic        pwd;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic push(input string name, input logic v, input logic pk, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] ctrl,
                        input logic [2:0] exc, input logic pwd, input logic [31:0] d1,
                        input logic [31:0] d2);
        exp_t e;
        e.name = name; e.valid = v; e.pc_known = pk; e.pc = pc; e.imm = imm; e.rd = rd;
        e.ctrl = ctrl; e.exc = exc; e.pwd = pwd; e.d1 = d1; e.d2 = d2;
        sb_q.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [6:0]  ctrl;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        ctrl = {dif.out_reg_write, dif.out_mem_read, dif.out_mem_write, dif.out_mem_to_reg,
                dif.out_branch, dif.out_jump, dif.out_alu_src};
        chk($sformatf("%s.valid", e.name), 32'(dif.out_valid), 32'(e.valid));
        if (e.pc_known) chk($sformatf("%s.pc", e.name), dif.out_PC, e.pc);
        chk($sformatf("%s.imm", e.name), dif.out_imm, e.imm);
        chk($sformatf("%s.rd", e.name), 32'(dif.out_rd), 32'(e.rd));
        chk($sformatf("%s.ctrl", e.name), 32'(ctrl), 32'(e.ctrl));
        chk($sformatf("%s.exc", e.name), 32'(dif.out_exception_vector), 32'(e.exc));
        chk($sformatf("%s.pwd", e.name), 32'(dif.out_pc_write_disable), 32'(e.pwd));
        chk($sformatf("%s.rs1_data", e.name), dif.out_rs1_data, e.d1);
        chk($sformatf("%s.rs2_data", e.name), dif.out_rs2_data, e.d2);
        $display("txn %s valid=%0b pc=%h imm=%h rd=%0d ctrl=%b exc=%0d pwd=%0b rs1d=%h rs2d=%h",
                 e.name, dif.out_valid, dif.out_PC, dif.out_imm, dif.out_rd, ctrl,
                 dif.out_exception_vector, dif.out_pc_write_disable, dif.out_rs1_data, dif.out_rs2_data);
    endtask

    // Present one fetch word, apply side inputs while it sits in decode,
    // check it, then let one more edge pass before clearing the side inputs.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic [2:0] fexc,
                         input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                         input logic ex_mr, input logic [4:0] ex_rd, input logic flush);
        dif.in_PC = pc;
        dif.in_instruction = instr;
        dif.in_exception_vector = fexc;
        dif.in_fetch_stall = 1'b0;
        @(posedge clk); #1;
        dif.in_fetch_stall = 1'b1;
        dif.in_wb_write_en = wb_en;
        dif.in_wb_rd = wb_rd;
        dif.in_wb_data = wb_data;
        dif.in_ex_mem_read = ex_mr;
        dif.in_ex_rd = ex_rd;
        dif.in_flush = flush;
        @(negedge clk);
        check_next();
        @(posedge clk); #1;
        dif.in_wb_write_en = 1'b0;
        dif.in_wb_rd = 5'd0;
        dif.in_wb_data = 32'b0;
        dif.in_ex_mem_read = 1'b0;
        dif.in_ex_rd = 5'd0;
        dif.in_flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        dif.in_PC = 32'b0;
        dif.in_instruction = 32'b0;
        dif.in_fetch_stall = 1'b1;
        dif.in_exception_vector = 3'd0;
        dif.in_flush = 1'b0;
        dif.in_stall = 1'b0;
        dif.in_ex_mem_read = 1'b0;
        dif.in_ex_rd = 5'd0;
        dif.in_wb_write_en = 1'b0;
        dif.in_wb_rd = 5'd0;
        dif.in_wb_data = 32'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        push("reset", 0, 1, 32'h0, 32'h0, 5'd0, 7'b0, 3'd0, 0, 32'h0, 32'h0);
        @(negedge clk); check_next();

        push("addi", 1, 1, 32'h200, 32'h5, 5'd1, 7'b1000001, 3'd0, 0, 32'h0, 32'h0);
        issue(32'h200, 32'h00500093, 3'd0, 1, 5'd1, 32'h11, 0, 5'd0, 0);
        push("fetch_bubble", 0, 0, 32'h0, 32'h0, 5'd0, 7'b0, 3'd0, 0, 32'h0, 32'h0);
        @(negedge clk); check_next();

        push("add_bypass", 1, 1, 32'h204, 32'h0, 5'd4, 7'b1000000, 3'd0, 0, 32'hDEADBEEF, 32'hDEADBEEF);
        issue(32'h204, 32'h00318233, 3'd0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0);

        push("addi_x0_write", 1, 1, 32'h208, 32'h5, 5'd1, 7'b1000001, 3'd0, 0, 32'h0, 32'h0);
        issue(32'h208, 32'h00500093, 3'd0, 1, 5'd0, 32'h7, 0, 5'd0, 0);

        push("add_x0_read", 1, 1, 32'h20C, 32'h0, 5'd7, 7'b1000000, 3'd0, 0, 32'h0, 32'hDEADBEEF);
        issue(32'h20C, 32'h003003B3, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("load_use", 0, 1, 32'h210, 32'h0, 5'd6, 7'b0, 3'd0, 1, 32'h0, 32'h11);
        issue(32'h210, 32'h00128333, 3'd0, 0, 5'd0, 32'h0, 1, 5'd5, 0);
        push("resume", 1, 1, 32'h210, 32'h0, 5'd6, 7'b1000000, 3'd0, 0, 32'h0, 32'h11);
        @(negedge clk); check_next();

        push("flush_hazard", 0, 1, 32'h214, 32'h0, 5'd6, 7'b0, 3'd0, 0, 32'h0, 32'h11);
        issue(32'h214, 32'h00128333, 3'd0, 0, 5'd0, 32'h0, 1, 5'd1, 1);
        push("after_flush", 0, 0, 32'h0, 32'h0, 5'd0, 7'b0, 3'd0, 0, 32'h0, 32'h0);
        @(negedge clk); check_next();

        push("illegal", 0, 1, 32'h218, 32'h0, 5'd31, 7'b0, 3'd2, 0, 32'h0, 32'h0);
        issue(32'h218, 32'hFFFFFFFF, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("fetch_exc", 0, 1, 32'h21C, 32'h0, 5'd31, 7'b0, 3'd5, 0, 32'h0, 32'h0);
        issue(32'h21C, 32'hFFFFFFFF, 3'd5, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("beq", 1, 1, 32'h220, 32'hFFFFFFFC, 5'd29, 7'b0000100, 3'd0, 0, 32'h0, 32'h0);
        issue(32'h220, 32'hFE000EE3, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("lw", 1, 1, 32'h224, 32'hFFFFFFF8, 5'd2, 7'b1101001, 3'd0, 0, 32'h11, 32'h0);
        issue(32'h224, 32'hFF80A103, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("sw", 1, 1, 32'h228, 32'hC, 5'd12, 7'b0010001, 3'd0, 0, 32'h11, 32'hDEADBEEF);
        issue(32'h228, 32'h0030A623, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("lui", 1, 1, 32'h22C, 32'h12345000, 5'd5, 7'b1000001, 3'd0, 0, 32'h0, 32'hDEADBEEF);
        issue(32'h22C, 32'h123452B7, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        push("jal", 1, 1, 32'h230, 32'h8, 5'd1, 7'b1000011, 3'd0, 0, 32'h0, 32'h0);
        issue(32'h230, 32'h008000EF, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        dif.in_PC = 32'h300;
        dif.in_instruction = 32'h00500093;
        dif.in_exception_vector = 3'd0;
        dif.in_fetch_stall = 1'b0;
        @(posedge clk); #1;
        dif.in_fetch_stall = 1'b1;
        dif.in_stall = 1'b1;
        push("stall", 1, 1, 32'h300, 32'h5, 5'd1, 7'b1000001, 3'd0, 1, 32'h0, 32'h0);
        @(negedge clk); check_next();
        @(posedge clk); #1;
        push("stall_hold", 1, 1, 32'h300, 32'h5, 5'd1, 7'b1000001, 3'd0, 1, 32'h0, 32'h0);
        @(negedge clk); check_next();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        push("reset_in_stall", 0, 1, 32'h0, 32'h0, 5'd0, 7'b0, 3'd0, 1, 32'h0, 32'h0);
        @(negedge clk); check_next();
        dif.in_stall = 1'b0;

        push("rf_cleared", 1, 1, 32'h304, 32'h0, 5'd4, 7'b1000000, 3'd0, 0, 32'h0, 32'h0);
        issue(32'h304, 32'h00318233, 3'd0, 0, 5'd0, 32'h0, 0, 5'd0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
